pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_pkg.sv | 13 +
 rtl/pc_ras.sv | 60 ++++++
 rtl/pc_gen.sv | 119 +++++++++++
 tb/tb_pc_gen.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator and its return-address stack.
package pc_pkg;

    localparam int unsigned XLEN_DEF       = 32;
    localparam int unsigned INST_BYTES_DEF = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest entry.
// Simultaneous push and pop replace the top entry in place.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o,
    output logic            full_o
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] wr_idx;
    logic [CNT_W-1:0] cnt_q;

    assign ptr_inc = ptr_q + PTR_W'(1);
    assign wr_idx  = pop_i ? ptr_q : ptr_inc;
    assign top_o   = mem_q[ptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(RAS_DEPTH));

    // Pointer and occupancy tracking; pointer wraps naturally since depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push_i && pop_i) begin
            ptr_q <= ptr_q;
            cnt_q <= cnt_q;
        end else if (push_i) begin
            ptr_q <= ptr_inc;
            if (!full_o) cnt_q <= cnt_q + CNT_W'(1);
        end else if (pop_i && !empty_o) begin
            ptr_q <= ptr_q - PTR_W'(1);
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Entry storage; contents are only meaningful while counted, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_idx] <= data_i;
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: BOOT/RUN/HALT sequencing, trap and redirect
// handling, and call/return prediction through a small return-address stack.
// ras_underflow is combinational from registered state and the ret input.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC   = 32'h0000_0100,
    parameter int unsigned     INST_BYTES = INST_BYTES_DEF,
    parameter int unsigned     RAS_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            halt,
    input  logic            trap,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic            ras_underflow
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));

    pc_state_e       state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            pc_valid_q;

    logic            in_run;
    logic            in_halt;
    logic            take_trap;
    logic            take_redir;
    logic            take_halt;
    logic            advance;
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full_unused;

    assign pc_seq = pc_q + XLEN'(INST_BYTES);

    // Event decode in priority order: trap > redirect > halt > stall > ret > sequential.
    always_comb begin
        in_run        = (state_q == ST_RUN);
        in_halt       = (state_q == ST_HALT);
        take_trap     = (in_run || in_halt) && trap;
        take_redir    = (in_run || in_halt) && !trap && redirect_valid;
        take_halt     = in_run && !trap && !redirect_valid && halt;
        advance       = in_run && !trap && !redirect_valid && !halt && !stall;
        ras_pop       = advance && ret && !ras_empty;
        ras_underflow = advance && ret && ras_empty;
        ras_push      = advance && call;
        if (take_trap)       pc_d = TRAP_VEC;
        else if (take_redir) pc_d = redirect_target & ALIGN_MASK;
        else if (ras_pop)    pc_d = ras_top;
        else if (advance)    pc_d = pc_seq;
        else                 pc_d = pc_q;
    end

    // Sequencing FSM with registered pc_out and pc_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            pc_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q    <= ST_RUN;
                    pc_valid_q <= 1'b1;
                end
                ST_RUN: begin
                    pc_q <= pc_d;
                    if (take_halt) begin
                        state_q    <= ST_HALT;
                        pc_valid_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    pc_q <= pc_d;
                    if (take_trap || take_redir) begin
                        state_q    <= ST_RUN;
                        pc_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_BOOT;
                    pc_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out   = pc_q;
    assign pc_valid = pc_valid_q;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .clear_i (take_trap),
        .data_i  (pc_seq),
        .top_o   (ras_top),
        .empty_o (ras_empty),
        .full_o  (ras_full_unused)
    );

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with hand-computed expected PC sequences.
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        halt;
    logic        trap;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        call;
    logic        ret;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        ras_underflow;

    int errors = 0;
    int checks = 0;

    pc_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .halt            (halt),
        .trap            (trap),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .call            (call),
        .ret             (ret),
        .pc_out          (pc_out),
        .pc_valid        (pc_valid),
        .ras_underflow   (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [31:0] addr);
        redirect_valid  = 1'b1;
        redirect_target = addr;
        step();
        redirect_valid  = 1'b0;
        chk("goto_pc", pc_out, addr & 32'hFFFF_FFFC);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; halt = 1'b0; trap = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0; call = 1'b0; ret = 1'b0;

        // reset values
        #2;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", {31'b0, pc_valid}, 32'h0);
        chk("rst_uf", {31'b0, ras_underflow}, 32'h0);
        step(); step();
        rst_n = 1'b1;

        // BOOT one cycle, then sequential fetch
        chk("boot_valid", {31'b0, pc_valid}, 32'h0);
        step();
        chk("run_valid", {31'b0, pc_valid}, 32'h1);
        chk("seq0", pc_out, 32'h0);
        step(); chk("seq4", pc_out, 32'h4);
        step(); chk("seq8", pc_out, 32'h8);
        step(); chk("seqC", pc_out, 32'hC);

        // stall with redirect in the middle, target alignment
        go_to(32'h10);
        stall = 1'b1;
        step(); chk("stall1", pc_out, 32'h10);
        redirect_valid = 1'b1; redirect_target = 32'h203;
        step(); chk("stall_redir", pc_out, 32'h200);
        redirect_valid = 1'b0;
        step(); chk("stall3", pc_out, 32'h200);
        stall = 1'b0;
        step(); chk("after_stall", pc_out, 32'h204);

        // nested calls and returns
        go_to(32'h40);
        call = 1'b1; step(); call = 1'b0;
        chk("call1_seq", pc_out, 32'h44);
        go_to(32'h80);
        call = 1'b1; step(); call = 1'b0;
        chk("call2_seq", pc_out, 32'h84);
        ret = 1'b1;
        #1 chk("ret1_uf", {31'b0, ras_underflow}, 32'h0);
        step(); chk("ret1_pc", pc_out, 32'h84);
        step(); chk("ret2_pc", pc_out, 32'h44);
        chk("ret3_uf", {31'b0, ras_underflow}, 32'h1);
        step(); chk("ret3_pc", pc_out, 32'h48);
        ret = 1'b0;
        #1 chk("uf_pulse_end", {31'b0, ras_underflow}, 32'h0);

        // overflow: five calls into a four-deep stack
        go_to(32'h1000);
        call = 1'b1;
        for (int i = 0; i < 5; i++) step();
        call = 1'b0;
        chk("calls5_pc", pc_out, 32'h1014);
        go_to(32'h2000);
        ret = 1'b1;
        step(); chk("ovf_ret1", pc_out, 32'h1014);
        step(); chk("ovf_ret2", pc_out, 32'h1010);
        step(); chk("ovf_ret3", pc_out, 32'h100C);
        step(); chk("ovf_ret4", pc_out, 32'h1008);
        chk("ovf_ret5_uf", {31'b0, ras_underflow}, 32'h1);
        step(); chk("ovf_ret5_pc", pc_out, 32'h100C);
        ret = 1'b0;

        // call and ret together replace the top entry
        go_to(32'h3000);
        call = 1'b1; step();
        chk("cr_call", pc_out, 32'h3004);
        ret = 1'b1; step();
        chk("cr_both", pc_out, 32'h3004);
        call = 1'b0;
        step(); chk("cr_ret", pc_out, 32'h3008);
        chk("cr_empty_uf", {31'b0, ras_underflow}, 32'h1);
        ret = 1'b0;

        // halt holds PC, trap exits; trap also clears the stack
        go_to(32'h30);
        call = 1'b1; halt = 1'b1;
        step();
        call = 1'b0; halt = 1'b0;
        chk("halt_pc", pc_out, 32'h30);
        chk("halt_valid", {31'b0, pc_valid}, 32'h0);
        ret = 1'b1; stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("halt_uf", {31'b0, ras_underflow}, 32'h0);
            step();
            chk("halt_hold", pc_out, 32'h30);
        end
        ret = 1'b0; stall = 1'b0;
        chk("halt_valid_end", {31'b0, pc_valid}, 32'h0);
        trap = 1'b1; step(); trap = 1'b0;
        chk("trap_pc", pc_out, 32'h100);
        chk("trap_valid", {31'b0, pc_valid}, 32'h1);
        call = 1'b1; step(); call = 1'b0;
        trap = 1'b1; step(); trap = 1'b0;
        ret = 1'b1;
        #1 chk("trap_clr_uf", {31'b0, ras_underflow}, 32'h1);
        step(); chk("trap_clr_pc", pc_out, 32'h104);
        ret = 1'b0;

        // wrap at top of address space
        go_to(32'hFFFF_FFFC);
        step(); chk("wrap", pc_out, 32'h0);

        // asynchronous reset mid-stream with three entries
        go_to(32'h500);
        call = 1'b1;
        for (int i = 0; i < 3; i++) step();
        call = 1'b0;
        chk("pre_rst_pc", pc_out, 32'h50C);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pc", pc_out, 32'h0);
        chk("async_rst_valid", {31'b0, pc_valid}, 32'h0);
        step();
        rst_n = 1'b1; ret = 1'b1;
        #1 chk("boot_ret_uf", {31'b0, ras_underflow}, 32'h0);
        step();
        chk("post_rst_pc", pc_out, 32'h0);
        chk("post_rst_uf", {31'b0, ras_underflow}, 32'h1);
        step();
        chk("post_rst_seq", pc_out, 32'h4);
        ret = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
